pf_ddr_dll_code_mgr: RTL and testbench

//  Parametrised manager wrapped around the DDR DLL primitive: sequences DLL power-up, qualifies LOCK,

---
 rtl/pf_ddr_dll_code_mgr_if.sv | 15 +
 rtl/pf_ddr_dll_code_mgr.sv | 208 ++++++++++++++++++++
 tb/tb_pf_ddr_dll_code_mgr.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pf_ddr_dll_code_mgr_if.sv
// Lane code distribution bus between the DLL code manager and the DDR PHY lanes.
//   lane_code  : delay code broadcast to every lane
//   lane_valid : per-lane valid, held until that lane acknowledges
//   lane_ack   : per-lane acknowledge back from the lane delay lines
interface pf_ddr_dll_code_mgr_if #(
  parameter int unsigned CODE_W    = 8,
  parameter int unsigned NUM_LANES = 4
);
  logic [CODE_W-1:0]    lane_code;
  logic [NUM_LANES-1:0] lane_valid;
  logic [NUM_LANES-1:0] lane_ack;

  modport master (output lane_code, output lane_valid, input lane_ack);
  modport slave  (input lane_code, input lane_valid, output lane_ack);
endinterface

// File: rtl/pf_ddr_dll_code_mgr.sv
// DDR DLL code manager: powers up the DLL, qualifies lock, strobes code
// updates (periodic or on request), captures the delay code and broadcasts
// it to the PHY lanes with a per-lane valid/ack handshake. Flags drift
// between consecutive codes and loss of lock.
//   sys_clk, sys_reset_n : clock, synchronous active-low reset
//   dll_lock, dll_code   : pre-synchronised DLL status and delay code
//   dll_powerdown_n      : DLL power enable (rises once after power-up wait)
//   dll_code_update      : one-cycle code update strobe to the DLL
//   refresh_req          : on-demand refresh pulse
//   code_ready           : a code has been fully distributed and lock held since
//   drift_flag, lock_lost: sticky status flags, cleared by clr_flags
//   lane                 : lane code distribution bus (master side)
module pf_ddr_dll_code_mgr #(
  parameter int unsigned CODE_W         = 8,
  parameter int unsigned NUM_LANES      = 4,
  parameter int unsigned PWRUP_CYCLES   = 32,
  parameter int unsigned LOCK_FILTER    = 16,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned REFRESH_PERIOD = 1024,
  parameter int unsigned DRIFT_TOL      = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset_n,
  input  logic                  dll_lock,
  input  logic [CODE_W-1:0]     dll_code,
  output logic                  dll_powerdown_n,
  output logic                  dll_code_update,
  input  logic                  refresh_req,
  output logic                  code_ready,
  output logic                  drift_flag,
  output logic                  lock_lost,
  input  logic                  clr_flags,
  pf_ddr_dll_code_mgr_if.master lane
);

  // One shared counter covers power-up, lock filter, settle and refresh timing.
  localparam int unsigned MAX_A   = (PWRUP_CYCLES > LOCK_FILTER) ? PWRUP_CYCLES : LOCK_FILTER;
  localparam int unsigned MAX_B   = (SETTLE_CYCLES > REFRESH_PERIOD) ? SETTLE_CYCLES : REFRESH_PERIOD;
  localparam int unsigned MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  localparam int unsigned DIFF_W  = CODE_W + 1;

  typedef enum logic [2:0] {
    ST_PWRDN,
    ST_WAIT_LOCK,
    ST_UPDATE,
    ST_SETTLE,
    ST_DIST,
    ST_IDLE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic [CODE_W-1:0]    held_q, held_d;
  logic                 held_valid_q, held_valid_d;
  logic [CODE_W-1:0]    lane_code_q, lane_code_d;
  logic [NUM_LANES-1:0] lane_valid_q, lane_valid_d;
  logic                 pwr_n_q, pwr_n_d;
  logic                 upd_q, upd_d;
  logic                 ready_q, ready_d;
  logic                 drift_q, drift_d;
  logic                 lost_q, lost_d;

  logic [DIFF_W-1:0]    ext_new, ext_held, diff;
  logic                 idle_go, serve;

  // Magnitude of code change, one bit wider so it never wraps.
  always_comb begin
    ext_new  = {1'b0, dll_code};
    ext_held = {1'b0, held_q};
    diff     = (ext_new >= ext_held) ? (ext_new - ext_held) : (ext_held - ext_new);
  end

  // Refresh trigger in IDLE and the single pending-request bit.
  always_comb begin
    idle_go = pend_q | refresh_req | (cnt_q == CNT_W'(REFRESH_PERIOD - 1));
    serve   = (state_q == ST_IDLE) && dll_lock && idle_go;
    pend_d  = serve ? 1'b0 : (pend_q | (refresh_req && (state_q != ST_PWRDN)));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    held_d       = held_q;
    held_valid_d = held_valid_q;
    lane_code_d  = lane_code_q;
    lane_valid_d = lane_valid_q;
    pwr_n_d      = pwr_n_q;
    upd_d        = 1'b0;
    ready_d      = ready_q;
    drift_d      = clr_flags ? 1'b0 : drift_q;
    lost_d       = clr_flags ? 1'b0 : lost_q;

    case (state_q)
      ST_PWRDN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(PWRUP_CYCLES - 1)) begin
          cnt_d   = '0;
          pwr_n_d = 1'b1;
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        if (cnt_q == CNT_W'(LOCK_FILTER)) begin
          cnt_d   = '0;
          upd_d   = 1'b1;
          state_d = ST_UPDATE;
        end else if (dll_lock) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      ST_UPDATE: begin
        cnt_d   = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SETTLE_CYCLES)) begin
          cnt_d        = '0;
          lane_code_d  = dll_code;
          lane_valid_d = '1;
          // First capture after reset or relock has no reference code.
          if (held_valid_q && (diff > DIFF_W'(DRIFT_TOL))) drift_d = 1'b1;
          state_d = ST_DIST;
        end
      end
      ST_DIST: begin
        lane_valid_d = lane_valid_q & ~lane.lane_ack;
        if (lane_valid_d == '0) begin
          held_d       = lane_code_q;
          held_valid_d = 1'b1;
          ready_d      = 1'b1;
          cnt_d        = '0;
          state_d      = ST_IDLE;
        end
      end
      ST_IDLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (idle_go) begin
          cnt_d   = '0;
          upd_d   = 1'b1;
          state_d = ST_UPDATE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_PWRDN;
      end
    endcase

    // Lock loss after qualification overrides everything else.
    if (!dll_lock && (state_q inside {ST_UPDATE, ST_SETTLE, ST_DIST, ST_IDLE})) begin
      state_d      = ST_WAIT_LOCK;
      cnt_d        = '0;
      upd_d        = 1'b0;
      lane_code_d  = lane_code_q;
      lane_valid_d = '0;
      held_d       = held_q;
      held_valid_d = 1'b0;
      ready_d      = 1'b0;
      lost_d       = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      state_q      <= ST_PWRDN;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      held_q       <= '0;
      held_valid_q <= 1'b0;
      lane_code_q  <= '0;
      lane_valid_q <= '0;
      pwr_n_q      <= 1'b0;
      upd_q        <= 1'b0;
      ready_q      <= 1'b0;
      drift_q      <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      held_q       <= held_d;
      held_valid_q <= held_valid_d;
      lane_code_q  <= lane_code_d;
      lane_valid_q <= lane_valid_d;
      pwr_n_q      <= pwr_n_d;
      upd_q        <= upd_d;
      ready_q      <= ready_d;
      drift_q      <= drift_d;
      lost_q       <= lost_d;
    end
  end

  assign dll_powerdown_n = pwr_n_q;
  assign dll_code_update = upd_q;
  assign code_ready      = ready_q;
  assign drift_flag      = drift_q;
  assign lock_lost       = lost_q;
  assign lane.lane_code  = lane_code_q;
  assign lane.lane_valid = lane_valid_q;

endmodule

// File: tb/tb_pf_ddr_dll_code_mgr.sv
// Directed bench for pf_ddr_dll_code_mgr. Cycle n is observed 1 time unit
// after the n-th rising edge following reset release; inputs set at that
// point take effect at the next edge.
module tb_pf_ddr_dll_code_mgr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dll_lock;
  logic [7:0] dll_code;
  logic       dll_powerdown_n;
  logic       dll_code_update;
  logic       refresh_req;
  logic       code_ready;
  logic       drift_flag;
  logic       lock_lost;
  logic       clr_flags;

  int n_cmp = 0;
  int n_bad = 0;

  pf_ddr_dll_code_mgr_if #(.CODE_W(8), .NUM_LANES(4)) lane_if ();

  pf_ddr_dll_code_mgr #(
    .CODE_W(8), .NUM_LANES(4), .PWRUP_CYCLES(32), .LOCK_FILTER(16),
    .SETTLE_CYCLES(4), .REFRESH_PERIOD(1024), .DRIFT_TOL(2)
  ) dut (
    .sys_clk         (clk),
    .sys_reset_n     (rst_n),
    .dll_lock        (dll_lock),
    .dll_code        (dll_code),
    .dll_powerdown_n (dll_powerdown_n),
    .dll_code_update (dll_code_update),
    .refresh_req     (refresh_req),
    .code_ready      (code_ready),
    .drift_flag      (drift_flag),
    .lock_lost       (lock_lost),
    .clr_flags       (clr_flags),
    .lane            (lane_if)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; dll_lock = 1'b1; dll_code = 8'h3A;
    refresh_req = 1'b0; clr_flags = 1'b0; lane_if.lane_ack = 4'h0;
    tick(3);
    chk("rst_pwr_n", 32'(dll_powerdown_n), 32'h0);
    chk("rst_code", 32'(lane_if.lane_code), 32'h0);
    chk("rst_valid", 32'(lane_if.lane_valid), 32'h0);
    chk("rst_ready", 32'(code_ready), 32'h0);
    chk("rst_flags", 32'({drift_flag, lock_lost, dll_code_update}), 32'h0);
    rst_n = 1'b1;                                   // cycle 0

    // Power-up, lock filter, first capture.
    tick(31); chk("c31_pwr_n", 32'(dll_powerdown_n), 32'h0);
    tick(1);  chk("c32_pwr_n", 32'(dll_powerdown_n), 32'h1);
    tick(16); chk("c48_upd", 32'(dll_code_update), 32'h0);
    tick(1);  chk("c49_upd", 32'(dll_code_update), 32'h1);
    tick(1);  chk("c50_upd", 32'(dll_code_update), 32'h0);
    tick(4);  chk("c54_valid", 32'(lane_if.lane_valid), 32'h0);
    tick(1);  chk("c55_valid", 32'(lane_if.lane_valid), 32'hF);
    chk("c55_code", 32'(lane_if.lane_code), 32'h3A);
    chk("c55_ready", 32'(code_ready), 32'h0);
    lane_if.lane_ack = 4'hF;
    tick(1);                                        // cycle 56, IDLE
    lane_if.lane_ack = 4'h0;
    chk("c56_valid", 32'(lane_if.lane_valid), 32'h0);
    chk("c56_ready", 32'(code_ready), 32'h1);
    chk("c56_drift", 32'(drift_flag), 32'h0);

    // Drift 0x3A -> 0x3D flagged, 0x3D -> 0x3C not, then cleared.
    dll_code = 8'h3D; refresh_req = 1'b1;
    tick(1); refresh_req = 1'b0;                    // cycle 57
    chk("c57_upd", 32'(dll_code_update), 32'h1);
    tick(5); chk("c62_valid", 32'(lane_if.lane_valid), 32'h0);
    tick(1);                                        // cycle 63
    chk("c63_code", 32'(lane_if.lane_code), 32'h3D);
    chk("c63_drift", 32'(drift_flag), 32'h1);
    chk("c63_ready", 32'(code_ready), 32'h1);
    lane_if.lane_ack = 4'hF; tick(1); lane_if.lane_ack = 4'h0;   // cycle 64
    dll_code = 8'h3C; refresh_req = 1'b1;
    tick(1); refresh_req = 1'b0;                    // cycle 65
    tick(6);                                        // cycle 71
    chk("c71_code", 32'(lane_if.lane_code), 32'h3C);
    chk("c71_drift", 32'(drift_flag), 32'h1);
    lane_if.lane_ack = 4'hF; tick(1); lane_if.lane_ack = 4'h0;   // cycle 72
    clr_flags = 1'b1; tick(1); clr_flags = 1'b0;    // cycle 73
    chk("c73_drift", 32'(drift_flag), 32'h0);

    // Lock drop during distribution with lanes 0 and 1 acked.
    dll_code = 8'h3D; refresh_req = 1'b1;
    tick(1); refresh_req = 1'b0;                    // cycle 74
    tick(6);                                        // cycle 80
    chk("c80_valid", 32'(lane_if.lane_valid), 32'hF);
    lane_if.lane_ack = 4'h3; tick(1); lane_if.lane_ack = 4'h0;   // cycle 81
    chk("c81_valid", 32'(lane_if.lane_valid), 32'hC);
    dll_lock = 1'b0;
    tick(1);                                        // cycle 82
    chk("c82_valid", 32'(lane_if.lane_valid), 32'h0);
    chk("c82_lost", 32'(lock_lost), 32'h1);
    chk("c82_ready", 32'(code_ready), 32'h0);
    chk("c82_code", 32'(lane_if.lane_code), 32'h3D);

    // Relock with a glitch at filter count 10.
    dll_lock = 1'b1; dll_code = 8'h50;
    tick(10); dll_lock = 1'b0;                      // cycle 92
    tick(1);  dll_lock = 1'b1;                      // cycle 93
    tick(6);  chk("c99_upd", 32'(dll_code_update), 32'h0);
    tick(10); chk("c109_upd", 32'(dll_code_update), 32'h0);
    tick(1);  chk("c110_upd", 32'(dll_code_update), 32'h1);
    tick(6);                                        // cycle 116
    chk("c116_valid", 32'(lane_if.lane_valid), 32'hF);
    chk("c116_code", 32'(lane_if.lane_code), 32'h50);
    chk("c116_drift", 32'(drift_flag), 32'h0);

    // Staggered acks: lanes 2, 0, 3, 1.
    tick(2); lane_if.lane_ack = 4'h4; tick(1); lane_if.lane_ack = 4'h0;   // 119
    chk("c119_valid", 32'(lane_if.lane_valid), 32'hB);
    chk("c119_ready", 32'(code_ready), 32'h0);
    tick(5); lane_if.lane_ack = 4'h1; tick(1); lane_if.lane_ack = 4'h0;   // 125
    chk("c125_valid", 32'(lane_if.lane_valid), 32'hA);
    tick(5); lane_if.lane_ack = 4'h8; tick(1); lane_if.lane_ack = 4'h0;   // 131
    chk("c131_valid", 32'(lane_if.lane_valid), 32'h2);
    chk("c131_code", 32'(lane_if.lane_code), 32'h50);
    chk("c131_ready", 32'(code_ready), 32'h0);
    lane_if.lane_ack = 4'h4; tick(1); lane_if.lane_ack = 4'h0;            // 132
    chk("c132_stale_ack", 32'(lane_if.lane_valid), 32'h2);
    tick(3); lane_if.lane_ack = 4'h2; tick(1); lane_if.lane_ack = 4'h0;   // 136
    chk("c136_valid", 32'(lane_if.lane_valid), 32'h0);
    chk("c136_ready", 32'(code_ready), 32'h1);
    chk("c136_lost", 32'(lock_lost), 32'h1);
    clr_flags = 1'b1; tick(1); clr_flags = 1'b0;    // cycle 137
    chk("c137_lost", 32'(lock_lost), 32'h0);

    // Two requests during SETTLE merge into one extra refresh; diff 2 is tolerated.
    dll_code = 8'h52; refresh_req = 1'b1;
    tick(1); refresh_req = 1'b0;                    // cycle 138
    tick(2); refresh_req = 1'b1; tick(1); refresh_req = 1'b0;   // 141
    tick(1); refresh_req = 1'b1; tick(1); refresh_req = 1'b0;   // 143
    tick(1);                                        // cycle 144
    chk("c144_code", 32'(lane_if.lane_code), 32'h52);
    chk("c144_drift", 32'(drift_flag), 32'h0);
    lane_if.lane_ack = 4'hF; tick(1); lane_if.lane_ack = 4'h0;   // cycle 145
    chk("c145_upd", 32'(dll_code_update), 32'h0);
    dll_code = 8'h55;
    tick(1); chk("c146_upd", 32'(dll_code_update), 32'h1);
    tick(5); clr_flags = 1'b1; tick(1); clr_flags = 1'b0;        // cycle 152
    chk("c152_code", 32'(lane_if.lane_code), 32'h55);
    chk("c152_drift_set_wins", 32'(drift_flag), 32'h1);
    lane_if.lane_ack = 4'hF; tick(1); lane_if.lane_ack = 4'h0;   // cycle 153
    tick(1); chk("c154_no_extra", 32'(dll_code_update), 32'h0);

    // Automatic refresh after 1024 IDLE cycles.
    tick(1022); chk("c1176_upd", 32'(dll_code_update), 32'h0);
    tick(1);    chk("c1177_upd", 32'(dll_code_update), 32'h1);
    tick(6);    chk("c1183_valid", 32'(lane_if.lane_valid), 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
